atomrv_wb_master: RTL and testbench

//  Parametrised Wishbone B4 classic master port for the AtomRV core; one instance per bus (IBUS, DBUS).

---
 rtl/atomrv_wb_master_pkg.sv | 17 +
 rtl/atomrv_wb_master_timeout_ctr.sv | 38 +++
 rtl/atomrv_wb_master.sv | 180 ++++++++++++++++++
 tb/tb_atomrv_wb_master.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/atomrv_wb_master_pkg.sv
// Shared definitions for the AtomRV Wishbone master: FSM state encoding and default widths.
package atomrv_wb_master_pkg;

  typedef enum logic {
    WB_ST_IDLE = 1'b0,
    WB_ST_BUSY = 1'b1
  } wb_state_e;

  localparam int WB_ADDR_W_DEF  = 32;
  localparam int WB_DATA_W_DEF  = 32;
  localparam int WB_TIMEOUT_DEF = 255;

  function automatic int wb_cnt_w(input int limit);
    return (limit < 2) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/atomrv_wb_master_timeout_ctr.sv
// Saturating wait-cycle counter for the Wishbone master; flags when LIMIT is reached.
module wb_timeout_ctr
  import atomrv_wb_master_pkg::*;
#(
  parameter int LIMIT = WB_TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic reached_o
);

  localparam int CW = wb_cnt_w(LIMIT);
  localparam logic [CW-1:0] LIM = CW'(LIMIT);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != LIM)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign reached_o = (cnt_q == LIM);

endmodule

// File: rtl/atomrv_wb_master.sv
// Wishbone B4 classic master port for the AtomRV core (one per bus).
// Optional posted-write path enabled by macro ATOMRV_WB_POSTED_WRITE_EN.
module atomrv_wb_master
  import atomrv_wb_master_pkg::*;
#(
  parameter  int ADDR_W  = WB_ADDR_W_DEF,
  parameter  int DATA_W  = WB_DATA_W_DEF,
  parameter  int TIMEOUT = WB_TIMEOUT_DEF,
  localparam int SEL_W   = DATA_W / 8
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  input  logic [ADDR_W-1:0] core_addr_i,
  input  logic [DATA_W-1:0] core_data_i,
  input  logic [SEL_W-1:0]  core_sel_i,
  input  logic              core_we_i,
  input  logic              core_valid_i,
  output logic [DATA_W-1:0] core_data_o,
  output logic              core_ack_o,
  output logic              core_err_o,
  output logic [ADDR_W-1:0] wb_adr_o,
  output logic [DATA_W-1:0] wb_dat_o,
  input  logic [DATA_W-1:0] wb_dat_i,
  output logic              wb_we_o,
  output logic [SEL_W-1:0]  wb_sel_o,
  output logic              wb_stb_o,
  output logic              wb_cyc_o,
  input  logic              wb_ack_i,
  input  logic              wb_err_i,
  output logic              posted_err_o
);

  wb_state_e         state_q, state_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [DATA_W-1:0] wdat_q, wdat_d;
  logic [DATA_W-1:0] rdat_q, rdat_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              we_q, we_d;
  logic              stb_q, stb_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic              tmo_clr, tmo_en, tmo_hit;
  logic              done, fail;
  logic              posted_q;

`ifdef ATOMRV_WB_POSTED_WRITE_EN
  logic posted_d, perr_q, perr_d;
  assign posted_err_o = perr_q;
`else
  assign posted_q     = 1'b0;
  assign posted_err_o = 1'b0;
`endif

  generate
    if (TIMEOUT > 0) begin : g_tmo
      wb_timeout_ctr #(.LIMIT(TIMEOUT)) u_tmo (
        .clk      (wb_clk_i),
        .rst_n    (wb_rst_ni),
        .clr      (tmo_clr),
        .en       (tmo_en),
        .reached_o(tmo_hit)
      );
    end else begin : g_no_tmo
      assign tmo_hit = 1'b0;
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    wdat_d  = wdat_q;
    sel_d   = sel_q;
    we_d    = we_q;
    stb_d   = stb_q;
    rdat_d  = rdat_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    tmo_clr = 1'b0;
    tmo_en  = 1'b0;
    done    = 1'b0;
    fail    = 1'b0;
`ifdef ATOMRV_WB_POSTED_WRITE_EN
    posted_d = posted_q;
    perr_d   = perr_q;
`endif
    if (state_q == WB_ST_IDLE) begin
      // The ack/err guard stops the still-high valid of the answered request relaunching.
      if (core_valid_i && !ack_q && !err_q) begin
        state_d = WB_ST_BUSY;
        adr_d   = core_addr_i;
        wdat_d  = core_data_i;
        sel_d   = core_sel_i;
        we_d    = core_we_i;
        stb_d   = 1'b1;
        tmo_clr = 1'b1;
`ifdef ATOMRV_WB_POSTED_WRITE_EN
        posted_d = core_we_i;
        ack_d    = core_we_i;
`endif
      end
    end else begin
      if (wb_err_i) begin
        done = 1'b1;
        fail = 1'b1;
      end else if (wb_ack_i) begin
        done = 1'b1;
      end else if (tmo_hit) begin
        done = 1'b1;
        fail = 1'b1;
      end else begin
        tmo_en = 1'b1;
      end
      if (done) begin
        state_d = WB_ST_IDLE;
        stb_d   = 1'b0;
        if (!posted_q) begin
          if (fail) begin
            err_d  = 1'b1;
            rdat_d = '0;
          end else begin
            ack_d = 1'b1;
            if (!we_q) rdat_d = wb_dat_i;
          end
        end
`ifdef ATOMRV_WB_POSTED_WRITE_EN
        // A posted write already answered the core; failures only raise the sticky flag.
        if (posted_q && fail) perr_d = 1'b1;
        posted_d = 1'b0;
`endif
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= WB_ST_IDLE;
      adr_q   <= '0;
      wdat_q  <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      stb_q   <= 1'b0;
      rdat_q  <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      wdat_q  <= wdat_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      stb_q   <= stb_d;
      rdat_q  <= rdat_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

`ifdef ATOMRV_WB_POSTED_WRITE_EN
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      posted_q <= 1'b0;
      perr_q   <= 1'b0;
    end else begin
      posted_q <= posted_d;
      perr_q   <= perr_d;
    end
  end
`endif

  assign wb_adr_o    = adr_q;
  assign wb_dat_o    = wdat_q;
  assign wb_sel_o    = sel_q;
  assign wb_we_o     = we_q;
  assign wb_stb_o    = stb_q;
  assign wb_cyc_o    = stb_q;
  assign core_data_o = rdat_q;
  assign core_ack_o  = ack_q;
  assign core_err_o  = err_q;

endmodule

// File: tb/tb_atomrv_wb_master.sv
// Scoreboard bench for atomrv_wb_master (TIMEOUT=8); follows ATOMRV_WB_POSTED_WRITE_EN if defined.
module tb_atomrv_wb_master;

  localparam int TMO = 8;
`ifdef ATOMRV_WB_POSTED_WRITE_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif

  localparam int K_ACK = 0, K_ERR = 1, K_BOTH = 2, K_SILENT = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] core_addr_i = '0, core_data_i = '0;
  logic [3:0]  core_sel_i = '0;
  logic        core_we_i = 1'b0, core_valid_i = 1'b0;
  logic [31:0] core_data_o;
  logic        core_ack_o, core_err_o;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic [31:0] wb_dat_i = '0;
  logic        wb_we_o, wb_stb_o, wb_cyc_o;
  logic [3:0]  wb_sel_o;
  logic        wb_ack_i = 1'b0, wb_err_i = 1'b0;
  logic        posted_err_o;

  atomrv_wb_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .core_addr_i(core_addr_i), .core_data_i(core_data_i), .core_sel_i(core_sel_i),
    .core_we_i(core_we_i), .core_valid_i(core_valid_i),
    .core_data_o(core_data_o), .core_ack_o(core_ack_o), .core_err_o(core_err_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_we_o(wb_we_o),
    .wb_sel_o(wb_sel_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .posted_err_o(posted_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [3:0]  sel;
    logic        we;
    int          w;
    int          kind;
    int          len;
  } bus_cfg_t;

  typedef struct {
    logic        is_err;
    logic        chk;
    logic [31:0] data;
  } resp_t;

  bus_cfg_t    cfgq[$];
  resp_t       expq[$];
  logic [31:0] last_data = '0;
  logic        exp_perr = 1'b0;
  int          total = 0;
  int          bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Response monitor: every core pulse is matched against the oldest prediction.
  always @(negedge clk) begin
    if (!rst_n) begin
      expq.delete();
    end else begin
      check("cyc_eq_stb", wb_cyc_o, wb_stb_o);
      if (core_ack_o || core_err_o) begin
        if (expq.size() == 0) begin
          check("unexpected_resp", {core_ack_o, core_err_o}, 2'b00);
        end else begin
          resp_t r;
          r = expq.pop_front();
          check("resp_ack", core_ack_o, !r.is_err);
          check("resp_err", core_err_o, r.is_err);
          if (r.chk) check("resp_data", core_data_o, r.data);
        end
      end
    end
  end

  // Slave model: answers each bus cycle per its configuration and checks bus stability and length.
  bus_cfg_t cur;
  bit       active = 1'b0;
  int       bcnt = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      active = 1'b0;
      cfgq.delete();
      wb_ack_i = 1'b0;
      wb_err_i = 1'b0;
    end else if (wb_stb_o) begin
      if (!active) begin
        active = 1'b1;
        bcnt   = 0;
        if (cfgq.size() == 0) begin
          check("unexpected_bus_cycle", 32'd1, 32'd0);
          cur = '{addr: wb_adr_o, wdata: wb_dat_o, rdata: 32'h0, sel: wb_sel_o, we: wb_we_o,
                  w: 0, kind: K_SILENT, len: TMO + 1};
        end else begin
          cur = cfgq.pop_front();
        end
      end
      check("wb_adr", wb_adr_o, cur.addr);
      check("wb_we", wb_we_o, cur.we);
      check("wb_sel", wb_sel_o, cur.sel);
      if (cur.we) check("wb_dat", wb_dat_o, cur.wdata);
      wb_ack_i = (bcnt == cur.w) && (cur.kind == K_ACK || cur.kind == K_BOTH);
      wb_err_i = (bcnt == cur.w) && (cur.kind == K_ERR || cur.kind == K_BOTH);
      wb_dat_i = (bcnt == cur.w) ? cur.rdata : $urandom;
      bcnt++;
    end else begin
      if (active) begin
        check("stb_len", bcnt, cur.len);
        active = 1'b0;
      end
      wb_ack_i = 1'b0;
      wb_err_i = 1'b0;
    end
  end

  // Issues one request; predictions come from the bus outcome rules, not from DUT state.
  task automatic do_req(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] sel,
                        input logic we, input int w, input int kind, input logic [31:0] rdata,
                        input bit hold_extra, output int lat);
    bus_cfg_t c;
    resp_t    r;
    bit       timed_out, fail, fin;
    timed_out = (kind == K_SILENT) || (w > TMO);
    fail      = timed_out || (kind != K_ACK);
    c = '{addr: addr, wdata: wdata, rdata: rdata, sel: sel, we: we, w: w, kind: kind,
          len: timed_out ? TMO + 1 : w + 1};
    cfgq.push_back(c);
    if (POSTED && we) begin
      r = '{is_err: 1'b0, chk: 1'b0, data: 32'h0};
      if (fail) exp_perr = 1'b1;
    end else if (fail) begin
      r = '{is_err: 1'b1, chk: 1'b1, data: 32'h0};
      last_data = '0;
    end else if (we) begin
      r = '{is_err: 1'b0, chk: 1'b1, data: last_data};
    end else begin
      r = '{is_err: 1'b0, chk: 1'b1, data: rdata};
      last_data = rdata;
    end
    expq.push_back(r);
    @(posedge clk); #1;
    core_addr_i  = addr;
    core_data_i  = wdata;
    core_sel_i   = sel;
    core_we_i    = we;
    core_valid_i = 1'b1;
    lat = 0;
    fin = 1'b0;
    while (!fin) begin
      @(posedge clk); #1;
      lat++;
      if (core_ack_o || core_err_o) begin
        fin = 1'b1;
      end else if (lat > 100) begin
        check("resp_timeout", 32'd1, 32'd0);
        fin = 1'b1;
      end else if (!POSTED && wb_stb_o) begin
        core_addr_i = $urandom;
        core_data_i = $urandom;
        core_sel_i  = 4'($urandom_range(0, 15));
        core_we_i   = ~we;
      end
    end
    if (hold_extra) begin
      @(posedge clk); #1;
    end
    core_valid_i = 1'b0;
  endtask

  initial begin
    int lat;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_stb", wb_stb_o, 1'b0);
    check("rst_cyc", wb_cyc_o, 1'b0);
    check("rst_ack", core_ack_o, 1'b0);
    check("rst_err", core_err_o, 1'b0);
    check("rst_data", core_data_o, 32'h0);
    check("rst_adr", wb_adr_o, 32'h0);
    check("rst_wdat", wb_dat_o, 32'h0);
    check("rst_sel", wb_sel_o, 4'h0);
    check("rst_we", wb_we_o, 1'b0);
    check("rst_perr", posted_err_o, 1'b0);
    rst_n = 1'b1;

    do_req(32'h100, 32'h0, 4'hF, 1'b0, 0, K_ACK, 32'hDEADBEEF, 1'b0, lat);
    check("zero_wait_lat", lat, 2);
    do_req(32'h200, 32'hA5A5_1234, 4'b0011, 1'b1, 3, K_ACK, 32'h0, 1'b1, lat);
    check("write_lat", lat, POSTED ? 1 : 5);
    do_req(32'h300, 32'h0, 4'hF, 1'b0, 0, K_SILENT, 32'h1111_2222, 1'b0, lat);
    check("timeout_lat", lat, TMO + 2);
    do_req(32'h304, 32'h0, 4'hF, 1'b0, TMO, K_ACK, 32'h3333_4444, 1'b0, lat);
    check("ack_in_tmo_lat", lat, TMO + 2);
    do_req(32'h308, 32'h0, 4'hF, 1'b0, 2, K_BOTH, 32'h5555_6666, 1'b0, lat);
    do_req(32'h30C, 32'h0, 4'hF, 1'b0, 1, K_ACK, 32'h7777_8888, 1'b0, lat);
    do_req(32'h310, 32'hCAFE_0001, 4'b1100, 1'b1, 1, K_ERR, 32'h0, 1'b0, lat);
    repeat (4) @(posedge clk);
    #1;
    check("perr_before_rst", posted_err_o, exp_perr);

    // Reset in the middle of a stalled bus cycle.
    cfgq.push_back('{addr: 32'h400, wdata: 32'h0, rdata: 32'h0, sel: 4'hF, we: 1'b0,
                     w: 0, kind: K_SILENT, len: TMO + 1});
    @(posedge clk); #1;
    core_addr_i = 32'h400; core_sel_i = 4'hF; core_we_i = 1'b0; core_valid_i = 1'b1;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_stb", wb_stb_o, 1'b0);
    check("midrst_cyc", wb_cyc_o, 1'b0);
    check("midrst_ack", core_ack_o, 1'b0);
    check("midrst_err", core_err_o, 1'b0);
    check("midrst_data", core_data_o, 32'h0);
    check("midrst_perr", posted_err_o, 1'b0);
    core_valid_i = 1'b0;
    last_data = '0;
    exp_perr = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    do_req(32'h500, 32'h0, 4'hF, 1'b0, 0, K_ACK, 32'h0BAD_F00D, 1'b0, lat);
    check("post_rst_lat", lat, 2);

    // Write that errs followed directly by a read; a posted write makes the read wait.
    do_req(32'h600, 32'h1234_5678, 4'hF, 1'b1, 2, K_ERR, 32'h0, 1'b0, lat);
    do_req(32'h604, 32'h0, 4'hF, 1'b0, 0, K_ACK, 32'h600D_D474, 1'b0, lat);
    check("perr_after_write", posted_err_o, exp_perr);
    repeat (5) @(posedge clk);
    #1;
    check("perr_sticky", posted_err_o, exp_perr);

    for (int i = 0; i < 60; i++) begin
      int k, sel_r;
      k = $urandom_range(0, 9);
      sel_r = $urandom_range(1, 15);
      do_req($urandom, $urandom, 4'(sel_r), 1'($urandom_range(0, 1)), $urandom_range(0, 10),
             (k < 6) ? K_ACK : (k < 8) ? K_ERR : (k == 8) ? K_BOTH : K_SILENT,
             $urandom, 1'($urandom_range(0, 1)), lat);
    end

    repeat (20) @(posedge clk);
    #1;
    check("final_perr", posted_err_o, exp_perr);
    check("cfgq_drained", cfgq.size(), 0);
    check("expq_drained", expq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
